// File: rtl/run_ctrl_pkg.sv
// Shared state encoding and halt-cause codes for the run/halt/step sequencer.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_RESET = 2'd0;
  localparam logic [1:0] CAUSE_HALT  = 2'd1;
  localparam logic [1:0] CAUSE_BP    = 2'd2;
  localparam logic [1:0] CAUSE_STEP  = 2'd3;

endpackage

// File: rtl/run_counter.sv
// Free-running wrap counter with synchronous reset and increment enable.
module run_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else if (inc) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/run_ctrl.sv
// Run/halt/single-step sequencer producing the core commit enable.
// Optional PC breakpoint enabled by defining RUN_CTRL_BREAKPOINT_EN.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter bit RESET_RUN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic [31:0]      PC,
  input  logic [31:0]      bp_addr,
  input  logic             bp_valid,
  output logic             core_en,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_t     state, state_nxt;
  logic [1:0] cause_nxt;
  logic       bp_hit;

`ifdef RUN_CTRL_BREAKPOINT_EN
  // skip lets execution resume from a breakpoint PC without re-triggering on it
  logic skip;

  always_ff @(posedge clk) begin
    if (reset) skip <= 1'b0;
    else if (state == HALT && (run_req || step_req)) skip <= 1'b1;
    else if (core_en) skip <= 1'b0;
  end

  assign bp_hit = bp_valid & (PC == bp_addr) & ~skip;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_addr, bp_valid, PC};
  assign bp_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RESET_RUN ? RUN : HALT;
      halt_cause <= CAUSE_RESET;
    end else begin
      state      <= state_nxt;
      halt_cause <= cause_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cause_nxt = halt_cause;
    core_en   = 1'b0;
    case (state)
      HALT: begin
        if (run_req) state_nxt = RUN;
        else if (step_req) state_nxt = STEP;
      end
      RUN: begin
        core_en = ~halt_req & ~bp_hit;
        if (halt_req) begin
          state_nxt = HALT;
          cause_nxt = CAUSE_HALT;
        end else if (bp_hit) begin
          state_nxt = HALT;
          cause_nxt = CAUSE_BP;
        end
      end
      STEP: begin
        core_en   = 1'b1;
        state_nxt = HALT;
        cause_nxt = CAUSE_STEP;
      end
      default: state_nxt = HALT;
    endcase
    if (reset) core_en = 1'b0;
  end

  assign halted = (state == HALT);

  run_counter #(.CNT_W(CNT_W)) u_cycle (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .count (cycle_cnt)
  );

  run_counter #(.CNT_W(CNT_W)) u_instret (
    .clk   (clk),
    .reset (reset),
    .inc   (core_en),
    .count (instret_cnt)
  );

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed vector table, breakpoint/wrap sequences and a
// randomized phase, all checked against a behavioural model of two instances.
module tb_run_ctrl;

`ifdef RUN_CTRL_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0, bp_valid = 1'b0;
  logic [31:0] pc = '0, bp_addr = '0;

  logic        en0, halted0, en1, halted1;
  logic [1:0]  cause0, cause1;
  logic [31:0] cyc0, ins0;
  logic [3:0]  cyc1, ins1;

  run_ctrl #(.CNT_W(32), .RESET_RUN(1'b1)) dut (
    .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .PC(pc), .bp_addr(bp_addr), .bp_valid(bp_valid), .core_en(en0), .halted(halted0),
    .halt_cause(cause0), .cycle_cnt(cyc0), .instret_cnt(ins0));

  run_ctrl #(.CNT_W(4), .RESET_RUN(1'b0)) dut_w (
    .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .PC(pc), .bp_addr(bp_addr), .bp_valid(bp_valid), .core_en(en1), .halted(halted1),
    .halt_cause(cause1), .cycle_cnt(cyc1), .instret_cnt(ins1));

  int n_chk = 0, n_pass = 0;

  task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  // Behavioural model: mode is 'H', 'R' or 'S'; counters kept as plain integers.
  byte               m_mode [2];
  bit                m_skip [2];
  int unsigned       m_cause[2];
  longint unsigned   m_cyc  [2];
  longint unsigned   m_ins  [2];
  bit                m_en   [2];
  bit                m_bp   [2];
  bit                m_rr   [2] = '{1'b1, 1'b0};
  longint unsigned   m_mod  [2] = '{64'h1_0000_0000, 64'd16};
  bit                m_valid = 1'b0;

  task automatic apply(input bit r, rq, hq, sq, input logic [31:0] p, ba, input bit bv);
    reset = r; run_req = rq; halt_req = hq; step_req = sq;
    pc = p; bp_addr = ba; bp_valid = bv;
    #1;
    for (int i = 0; i < 2; i++) begin
      m_bp[i] = BP_EN && bv && (p == ba) && !m_skip[i];
      m_en[i] = !r && ((m_mode[i] == "R" && !hq && !m_bp[i]) || m_mode[i] == "S");
    end
    if (m_valid) begin
      check("core_en",     en0,     m_en[0]);
      check("halted",      halted0, m_mode[0] == "H");
      check("halt_cause",  cause0,  m_cause[0]);
      check("cycle_cnt",   cyc0,    m_cyc[0]);
      check("instret_cnt", ins0,    m_ins[0]);
      check("w_core_en",     en1,     m_en[1]);
      check("w_halted",      halted1, m_mode[1] == "H");
      check("w_halt_cause",  cause1,  m_cause[1]);
      check("w_cycle_cnt",   cyc1,    m_cyc[1]);
      check("w_instret_cnt", ins1,    m_ins[1]);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_mode[i] = m_rr[i] ? "R" : "H";
        m_cause[i] = 0; m_cyc[i] = 0; m_ins[i] = 0; m_skip[i] = 0;
      end else begin
        m_cyc[i] = (m_cyc[i] + 1) % m_mod[i];
        if (m_en[i]) m_ins[i] = (m_ins[i] + 1) % m_mod[i];
        case (m_mode[i])
          "H": if (run_req) begin m_mode[i] = "R"; m_skip[i] = 1; end
               else if (step_req) begin m_mode[i] = "S"; m_skip[i] = 1; end
          "R": if (halt_req) begin m_mode[i] = "H"; m_cause[i] = 1; end
               else if (m_bp[i]) begin m_mode[i] = "H"; m_cause[i] = 2; end
               else m_skip[i] = 0;
          default: begin m_mode[i] = "H"; m_cause[i] = 3; m_skip[i] = 0; end
        endcase
      end
    end
    m_valid = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    bit r, rq, hq, sq;
    bit en, h;
    int unsigned c, cyc, ins;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit r, rq, hq, sq, en, h, int unsigned c, cyc, ins);
    vec_t v;
    v.r = r; v.rq = rq; v.hq = hq; v.sq = sq; v.en = en; v.h = h;
    v.c = c; v.cyc = cyc; v.ins = ins;
    tbl.push_back(v);
  endfunction

  logic [31:0] pc_n;
  bit          done;

  initial begin
    // reset-run with no requests, then halt at cycle 5
    for (int k = 0; k < 10; k++) add(0,0,0,0, 1,0,0,k,k);
    add(1,0,0,0, 0,0,0,10,10);
    for (int k = 0; k < 5; k++) add(0,0,0,0, 1,0,0,k,k);
    add(0,0,1,0, 0,0,0,5,5);
    add(0,0,0,0, 0,1,1,6,5);
    add(0,0,0,0, 0,1,1,7,5);
    // three step pulses, 4 cycles apart; halt_req during the last STEP
    add(0,0,0,1, 0,1,1,8,5);
    add(0,0,0,0, 1,0,1,9,5);
    add(0,0,0,0, 0,1,3,10,6);
    add(0,0,0,0, 0,1,3,11,6);
    add(0,0,0,1, 0,1,3,12,6);
    add(0,0,0,0, 1,0,3,13,6);
    add(0,0,0,0, 0,1,3,14,7);
    add(0,0,0,0, 0,1,3,15,7);
    add(0,0,0,1, 0,1,3,16,7);
    add(0,0,1,0, 1,0,3,17,7);
    add(0,0,0,0, 0,1,3,18,8);
    // run+step together, halt ignored in HALT, step ignored in RUN
    add(0,1,0,1, 0,1,3,19,8);
    add(0,0,0,0, 1,0,3,20,8);
    add(0,0,0,0, 1,0,3,21,9);
    add(0,0,1,0, 0,0,3,22,10);
    add(0,0,1,0, 0,1,1,23,10);
    add(0,1,1,0, 0,1,1,24,10);
    add(0,0,0,0, 1,0,1,25,10);
    add(0,0,0,1, 1,0,1,26,11);
    add(0,0,0,0, 1,0,1,27,12);
    // held step_req re-steps every second cycle
    add(0,0,1,0, 0,0,1,28,13);
    add(0,0,0,1, 0,1,1,29,13);
    add(0,0,0,1, 1,0,1,30,13);
    add(0,0,0,1, 0,1,3,31,14);
    add(0,0,0,0, 1,0,3,32,14);
    add(0,0,0,0, 0,1,3,33,15);

    @(negedge clk);
    apply(1,0,0,0, 0,0,0);
    adv();
    foreach (tbl[k]) begin
      apply(tbl[k].r, tbl[k].rq, tbl[k].hq, tbl[k].sq, 0, 0, 0);
      check("tbl_core_en", en0,     tbl[k].en);
      check("tbl_halted",  halted0, tbl[k].h);
      check("tbl_cause",   cause0,  tbl[k].c);
      check("tbl_cycle",   cyc0,    tbl[k].cyc);
      check("tbl_instret", ins0,    tbl[k].ins);
      adv();
    end

    // counter wrap on the 4-bit instance, reset values of both instances
    apply(1,0,0,0, 0,0,0);
    adv();
    apply(0,0,0,0, 0,0,0);
    check("w_rst_halted", halted1, 1);
    check("w_rst_en",     en1,     0);
    check("rst_run",      halted0, 0);
    adv();
    for (int k = 1; k < 17; k++) begin apply(0,0,0,0, 0,0,0); adv(); end
    apply(0,0,0,0, 0,0,0);
    check("wrap_cyc4",  cyc1, 1);
    check("wrap_cyc32", cyc0, 17);
    adv();
    // reset in the middle of RUN
    apply(0,1,0,0, 0,0,0); adv();
    for (int k = 0; k < 3; k++) begin apply(0,0,0,0, 0,0,0); adv(); end
    apply(1,0,0,0, 0,0,0);
    check("rst_cycle_en",   en0, 0);
    check("rst_cycle_w_en", en1, 0);
    adv();
    apply(0,0,0,0, 0,0,0);
    check("midrst_cyc",     cyc0,    0);
    check("midrst_ins",     ins0,    0);
    check("midrst_w_cyc",   cyc1,    0);
    check("midrst_running", halted0, 0);
    check("midrst_en",      en0,     1);
    check("midrst_w_halt",  halted1, 1);
    check("midrst_w_en",    en1,     0);
    adv();

    // breakpoint at 0x10 with a core whose PC advances on each commit
    apply(1,0,0,0, 0,32'h10,1); adv();
    pc_n = 32'h0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      apply(0,0,0,0, pc_n, 32'h10, 1);
      pc_n = m_en[0] ? pc + 32'd4 : pc;
      adv();
      if (halted0) done = 1'b1;
    end
`ifdef RUN_CTRL_BREAKPOINT_EN
    check("bp_halted",  halted0, 1);
    check("bp_pc",      pc_n,    32'h10);
    check("bp_cause",   cause0,  2);
    check("bp_instret", ins0,    4);
    apply(0,1,0,0, pc_n, 32'h10, 1); adv();
    apply(0,0,0,0, pc_n, 32'h10, 1);
    check("bp_resume_en", en0, 1);
    pc_n = m_en[0] ? pc + 32'd4 : pc;
    adv();
    for (int k = 0; k < 5; k++) begin
      apply(0,0,0,0, pc_n, 32'h10, 1);
      pc_n = m_en[0] ? pc + 32'd4 : pc;
      adv();
    end
    check("bp_passed_halted", halted0, 0);
    check("bp_passed_pc",     pc_n,    32'h28);
    apply(0,0,0,0, 32'h10, 32'h10, 1);
    check("bp_rehit_en", en0, 0);
    adv();
    check("bp_rehit_cause", cause0, 2);
    // halt_req and breakpoint together: halt_req wins
    apply(0,1,0,0, 32'h10, 32'h10, 1); adv();
    apply(0,0,0,0, 32'h10, 32'h10, 1); adv();
    apply(0,0,1,0, 32'h10, 32'h10, 1); adv();
    check("bp_and_halt_cause", cause0, 1);
`else
    check("nobp_running", halted0, 0);
    check("nobp_cause",   cause0,  0);
`endif

    // randomized phase against the model
    for (int k = 0; k < 400; k++) begin
      logic [31:0] rp;
      case ($urandom_range(0, 3))
        0: rp = 32'h0;
        1: rp = 32'h4;
        2: rp = 32'h10;
        default: rp = 32'h14;
      endcase
      apply($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) == 0, rp, 32'h10, 1'($urandom_range(0, 1)));
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
